// File: rtl/rx_fifo_read_ctrl.sv
// Read sequencer for the first-word-fall-through USB receive FIFO: pops req_len bytes onto a valid/ready port.
// Optional macro RX_FIFO_FLUSH_EN adds a flush input that drains the FIFO without forwarding data.
module rx_fifo_read_ctrl #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  req_len,
`ifdef RX_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              fifo_r_enable,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [LEN_W-1:0]  bytes_left,
  output logic              done,
  output logic              err_timeout,
  output logic [2:0]        dbg_state
);

  // Output handshake: a byte transfers on every rising edge where out_valid && out_ready;
  // out_data/out_last stay stable while out_valid is high and out_ready is low.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LAST_ACK  = 3'd2,
    ABORT_ACK = 3'd3
`ifdef RX_FIFO_FLUSH_EN
    ,FLUSH    = 3'd4
`endif
  } state_t;

  localparam int TMR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state, state_next;
  logic [TMR_W-1:0] timer;
  logic             pop;
  logic             load;
  logic             accept;

  assign accept        = out_valid && out_ready;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;
  assign fifo_r_enable = pop && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
`ifdef RX_FIFO_FLUSH_EN
        if (flush) begin
          state_next = FLUSH;
        end else
`endif
        if (start) begin
          load = 1'b1;
          if (req_len != '0) state_next = READ;
        end
      end
      READ: begin
        pop = !fifo_empty && (bytes_left != '0) && (!out_valid || out_ready);
        if (pop && (bytes_left == LEN_W'(1)))   state_next = LAST_ACK;
        else if (fifo_empty && timer == TMR_MAX) state_next = ABORT_ACK;
      end
      LAST_ACK: begin
        if (accept) state_next = IDLE;
      end
      ABORT_ACK: begin
        if (!out_valid || accept) state_next = IDLE;
      end
`ifdef RX_FIFO_FLUSH_EN
      FLUSH: begin
        pop = !fifo_empty;
        if (fifo_empty) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      bytes_left  <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bytes_left <= req_len;
            timer      <= '0;
            done       <= (req_len == '0);
          end
        end
        READ: begin
          if (pop) begin
            out_data   <= fifo_r_data;
            out_valid  <= 1'b1;
            out_last   <= (bytes_left == LEN_W'(1));
            bytes_left <= bytes_left - LEN_W'(1);
            timer      <= '0;
          end else begin
            if (accept) out_valid <= 1'b0;
            // Only consecutive empty cycles count; a stalled consumer with data waiting does not.
            if (!fifo_empty)           timer <= '0;
            else if (timer != TMR_MAX) timer <= timer + TMR_W'(1);
          end
        end
        LAST_ACK: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        ABORT_ACK: begin
          if (accept) out_valid <= 1'b0;
          if (!out_valid || accept) begin
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
`ifdef RX_FIFO_FLUSH_EN
        FLUSH: begin
          if (fifo_empty) done <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
